// File: rtl/riscv_pkg.sv
// riscv_pkg: shared type definitions for the data memory slice.
//   size_e       RV32 load/store funct3 size encodings
//   dmem_state_e request handling states of data_memory
// Has no ports; imported with import riscv_pkg::*.
package riscv_pkg;

  typedef enum logic [2:0] {
    SIZE_B  = 3'b000,
    SIZE_H  = 3'b001,
    SIZE_W  = 3'b010,
    SIZE_BU = 3'b100,
    SIZE_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for data_memory.
// Builds the store byte mask and replicated store data, and extracts plus
// sign/zero-extends the load result from the addressed word.
// Ports:
//   size       in  funct3 access size
//   addr_lo    in  byte offset within the word
//   wdata      in  LSB-aligned store data
//   rword      in  full storage word at the addressed index
//   wmask      out byte enables for the store
//   wlane      out store data placed on every candidate lane
//   rdata      out extended load data
//   misaligned out offset not legal for the access size
//   bad_size   out funct3 is not a legal load/store size
// Macro DMEM_SUBWORD_EN enables byte/halfword accesses; without it every
// access is treated as a full word and size is ignored.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wlane,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bad_size
);

`ifdef DMEM_SUBWORD_EN
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rword[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    wmask      = 4'b0000;
    wlane      = wdata;
    rdata      = rword;
    misaligned = 1'b0;
    bad_size   = 1'b0;
    case (size)
      SIZE_B, SIZE_BU: begin
        wmask = 4'b0001 << addr_lo;
        wlane = {4{wdata[7:0]}};
        rdata = (size == SIZE_B) ? {{24{lane_byte[7]}}, lane_byte}
                                 : {24'h000000, lane_byte};
      end
      SIZE_H, SIZE_HU: begin
        wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlane      = {2{wdata[15:0]}};
        rdata      = (size == SIZE_H) ? {{16{lane_half[15]}}, lane_half}
                                      : {16'h0000, lane_half};
        misaligned = addr_lo[0];
      end
      SIZE_W: begin
        wmask      = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        bad_size = 1'b1;
      end
    endcase
  end
`else
  // Word-only build: size has no effect, so it is folded into a sink.
  logic size_unused;
  assign size_unused = ^size;

  assign wmask      = 4'b1111;
  assign wlane      = wdata;
  assign rdata      = rword;
  assign misaligned = (addr_lo != 2'b00);
  assign bad_size   = 1'b0;
`endif

endmodule

// File: rtl/data_memory.sv
// data_memory: single-port data memory with a fixed-latency request/response
// handshake.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-low reset
//   mem_read   in  load request
//   mem_write  in  store request
//   addr       in  byte address
//   wdata      in  store data, LSB-aligned
//   size       in  RV32 funct3 size
//   ready      out request accepted this cycle
//   rsp_valid  out one-cycle pulse, rdata/err valid
//   rdata      out load result (0 for stores and errors)
//   err        out access rejected
// Parameters: DEPTH_WORDS (32-bit words), WAIT_STATES (0..15).
// Macro DMEM_SUBWORD_EN enables byte/halfword accesses.
module data_memory
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  output logic        ready,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_e state, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic        armed;
  logic        accept;
  logic        enter_resp;

  logic        req_rd, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;

  logic        cur_rd, cur_wr;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_size;

  logic [IDX_W-1:0] word_idx;
  logic [31:0] mem [DEPTH_WORDS];

  logic [3:0]  wmask;
  logic [31:0] wlane, lane_rdata;
  logic        misaligned, bad_size, out_of_range, err_now;

  // With zero wait states the request enters RESP on the same edge that
  // accepts it, so the live inputs stand in for the not-yet-captured copy.
  assign cur_rd    = (state == ST_IDLE) ? mem_read  : req_rd;
  assign cur_wr    = (state == ST_IDLE) ? mem_write : req_wr;
  assign cur_addr  = (state == ST_IDLE) ? addr      : req_addr;
  assign cur_wdata = (state == ST_IDLE) ? wdata     : req_wdata;
  assign cur_size  = (state == ST_IDLE) ? size      : req_size;

  assign word_idx     = cur_addr[IDX_W+1:2];
  assign out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign err_now      = (cur_rd && cur_wr) || out_of_range || misaligned || bad_size;

  dmem_lane_align u_lane_align (
    .size       (cur_size),
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .rword      (mem[word_idx]),
    .wmask      (wmask),
    .wlane      (wlane),
    .rdata      (lane_rdata),
    .misaligned (misaligned),
    .bad_size   (bad_size)
  );

  // armed holds ready low until the first clock edge after reset release.
  assign ready     = armed && (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && (mem_read || mem_write)) begin
          accept     = 1'b1;
          state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt <= 4'd1) state_next = ST_RESP;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign enter_resp = (state_next == ST_RESP) && (state != ST_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      armed     <= 1'b0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_size  <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_next;
      if (accept) begin
        req_rd    <= mem_read;
        req_wr    <= mem_write;
        req_addr  <= addr;
        req_wdata <= wdata;
        req_size  <= size;
        wait_cnt  <= 4'(WAIT_STATES);
      end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        err   <= err_now;
        rdata <= (cur_rd && !err_now) ? lane_rdata : 32'h0;
      end
    end
  end

  // Storage is deliberately not reset; a store lands on the RESP entry edge,
  // so a reset before that edge drops it.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_wr && !err_now) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized self-checking bench for data_memory.
// Two instances: dut (WAIT_STATES=2, 1024 words) and dut0 (WAIT_STATES=0,
// 16 words). A byte-array reference model derives every expected response.
// Honours DMEM_SUBWORD_EN the same way the design does.
module tb_data_memory;

  localparam int DEPTH  = 1024;
  localparam int DEPTH0 = 16;
`ifdef DMEM_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  size = '0;
  logic        ready, rsp_valid, err;
  logic [31:0] rdata;

  logic        mem_read0 = 1'b0, mem_write0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [2:0]  size0 = '0;
  logic        ready0, rsp_valid0, err0;
  logic [31:0] rdata0;

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference storage: bytes 0..4095 mirror dut, 4096.. mirror dut0.
  logic [7:0] mdl [0:8191];

  always #5 clk = ~clk;

  data_memory #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .size(size), .ready(ready),
    .rsp_valid(rsp_valid), .rdata(rdata), .err(err)
  );

  data_memory #(.DEPTH_WORDS(DEPTH0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(mem_read0), .mem_write(mem_write0),
    .addr(addr0), .wdata(wdata0), .size(size0), .ready(ready0),
    .rsp_valid(rsp_valid0), .rdata(rdata0), .err(err0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit z, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd);
    if (z) begin
      mem_read0 = rd; mem_write0 = wr; addr0 = a; size0 = sz; wdata0 = wd;
    end else begin
      mem_read = rd; mem_write = wr; addr = a; size = sz; wdata = wd;
    end
  endtask

  // Access rules written directly from the memory's contract: legality,
  // little-endian bytes, extension by size.
  task automatic model_access(input bit z, input bit rd, input bit wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [31:0] wd,
                              output logic e, output logic [31:0] rv);
    int base, depth, nbytes;
    bit sgn;
    base   = z ? 4096 : 0;
    depth  = z ? DEPTH0 : DEPTH;
    e      = 1'b0;
    rv     = 32'h0;
    nbytes = 4;
    sgn    = 1'b0;
    if (SUBWORD) begin
      case (sz)
        3'd0: begin nbytes = 1; sgn = 1'b1; end
        3'd1: begin nbytes = 2; sgn = 1'b1; end
        3'd2: nbytes = 4;
        3'd4: nbytes = 1;
        3'd5: nbytes = 2;
        default: e = 1'b1;
      endcase
    end
    if (rd && wr) e = 1'b1;
    if ((a >> 2) >= 32'(depth)) e = 1'b1;
    if ((a % 32'(nbytes)) != 0) e = 1'b1;
    if (!e) begin
      if (wr) begin
        for (int k = 0; k < nbytes; k++) mdl[base + int'(a) + k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < nbytes; k++) rv = rv | ({24'h0, mdl[base + int'(a) + k]} << (8*k));
        if (sgn && rv[8*nbytes-1]) rv = rv | ~((32'h1 << (8*nbytes)) - 32'h1);
      end
    end
  endtask

  // Issues one request, scribbles junk on the inputs while it is pending,
  // and returns the response plus the cycle count from acceptance.
  task automatic applyStimulus(input bit z, input bit rd, input bit wr, input logic [31:0] a,
                               input logic [2:0] sz, input logic [31:0] wd,
                               output logic o_err, output logic [31:0] o_rdata, output int lat);
    int guard;
    guard = 0;
    while (((z ? ready0 : ready) !== 1'b1) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkOutput("ready_wait", 32'(z ? ready0 : ready), 32'd1);
    drive(z, rd, wr, a, sz, wd);
    @(posedge clk);
    @(negedge clk);
    drive(z, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    lat = 1;
    while (((z ? rsp_valid0 : rsp_valid) !== 1'b1) && lat < 40) begin
      if (!z) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom & 32'h3f, 3'($urandom_range(0, 7)), $urandom);
      @(negedge clk);
      lat++;
    end
    o_err   = z ? err0 : err;
    o_rdata = z ? rdata0 : rdata;
    drive(z, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic applyAndCheck(input bit z, input bit rd, input bit wr, input logic [31:0] a,
                               input logic [2:0] sz, input logic [31:0] wd, input string tag);
    logic        e, oe;
    logic [31:0] rv, ord;
    int          lat;
    model_access(z, rd, wr, a, sz, wd, e, rv);
    applyStimulus(z, rd, wr, a, sz, wd, oe, ord, lat);
    checkOutput({tag, "_err"}, 32'(oe), 32'(e));
    checkOutput({tag, "_rdata"}, ord, rv);
    checkOutput({tag, "_lat"}, 32'(lat), z ? 32'd1 : 32'd3);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          saw_rsp;
    logic        rd, wr;
    logic [31:0] a;
    logic [2:0]  sz;

    // Reset state and release timing.
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rel_ready_low", 32'(ready), 32'd0);
    @(negedge clk);
    checkOutput("rel_ready_high", 32'(ready), 32'd1);

    // Directed word, byte, alignment, conflict and range cases.
    applyAndCheck(0, 0, 1, 32'h10, 3'd2, 32'hDEADBEEF, "sw10");
    applyAndCheck(0, 1, 0, 32'h10, 3'd2, 32'h0, "lw10");
    @(negedge clk);
    checkOutput("ready_back", 32'(ready), 32'd1);
    applyAndCheck(0, 0, 1, 32'h13, 3'd0, 32'h80, "sb13");
    applyAndCheck(0, 1, 0, 32'h13, 3'd0, 32'h0, "lb13");
    applyAndCheck(0, 1, 0, 32'h13, 3'd4, 32'h0, "lbu13");
    applyAndCheck(0, 1, 0, 32'h10, 3'd2, 32'h0, "lw10_b");
    applyAndCheck(0, 1, 0, 32'h11, 3'd1, 32'h0, "lh11");
    applyAndCheck(0, 0, 1, 32'h12, 3'd2, 32'h55555555, "sw12");
    applyAndCheck(0, 1, 0, 32'h10, 3'd2, 32'h0, "lw10_c");
    applyAndCheck(0, 1, 1, 32'h10, 3'd2, 32'h12345678, "rdwr10");
    applyAndCheck(0, 1, 0, 32'h10, 3'd2, 32'h0, "lw10_d");
    applyAndCheck(0, 1, 0, 32'(4*DEPTH), 3'd2, 32'h0, "lw_range");
    applyAndCheck(0, 0, 1, 32'(4*DEPTH), 3'd2, 32'hCAFEF00D, "sw_range");

    // Reset while a store is waiting: it must vanish without a response.
    applyAndCheck(0, 0, 1, 32'h20, 3'd2, 32'h11112222, "sw20_old");
    applyAndCheck(0, 1, 0, 32'h20, 3'd2, 32'h0, "lw20_pre");
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h20, 3'd2, 32'h99998888);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(ready), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_rdata", rdata, 32'h0);
    checkOutput("mid_rst_err", 32'(err), 32'd0);
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    checkOutput("mid_rst_no_rsp", 32'(saw_rsp), 32'd0);
    applyAndCheck(0, 1, 0, 32'h20, 3'd2, 32'h0, "lw20_post");

    // Zero-wait-state instance.
    for (int w = 0; w < DEPTH0; w++) applyAndCheck(1, 0, 1, 32'(4*w), 3'd2, $urandom, "ws0_fill");
    applyAndCheck(1, 1, 0, 32'h8, 3'd2, 32'h0, "ws0_lw8");
    @(negedge clk);
    checkOutput("ws0_ready_back", 32'(ready0), 32'd1);
    applyAndCheck(1, 1, 0, 32'(4*DEPTH0), 3'd2, 32'h0, "ws0_range");

    // Randomized traffic on both instances over a preloaded region.
    for (int w = 0; w < 16; w++) applyAndCheck(0, 0, 1, 32'(4*w), 3'd2, $urandom, "fill");
    for (int i = 0; i < 200; i++) begin
      int r;
      r  = $urandom_range(0, 9);
      rd = (r == 0) || (r >= 5);
      wr = (r <= 4);
      a  = $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) a = 32'(4*DEPTH) + $urandom_range(0, 255);
      sz = 3'($urandom_range(0, 7));
      applyAndCheck(0, rd, wr, a, sz, $urandom, "rnd");
    end
    for (int i = 0; i < 80; i++) begin
      int r;
      r  = $urandom_range(0, 9);
      rd = (r == 0) || (r >= 5);
      wr = (r <= 4);
      a  = $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) a = 32'(4*DEPTH0) + $urandom_range(0, 255);
      sz = 3'($urandom_range(0, 7));
      applyAndCheck(1, rd, wr, a, sz, $urandom, "rnd0");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
